flash_read_bridge: RTL
======================

Name: flash_read_bridge

Overview:
- Bus-side front end for the 16-bit NOR flash driver.
- Accepts 32-bit word read requests from the CPU/memory bus and issues two sequential 16-bit read transactions to the flash driver.
- Assembles the two halfwords into one word and returns it with a one-cycle acknowledge.
- Holds a single-entry word cache, so a repeated read of the same word completes without a flash access.

Parameters:
- WORD_AW, 21: word address width; the flash halfword address is WORD_AW+1 bits.
- READ_WAIT, 10: cycles drv_read is held per halfword before drv_data is sampled; legal range 8..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bus_req  in  1  read request; level, held with bus_addr stable until bus_ack or bus_err.
- bus_addr  in  WORD_AW+2  byte address.
- bus_rdata  out  32  read data; valid in the bus_ack cycle, held until the next ack.
- bus_ack  out  1  one-cycle completion pulse.
- bus_err  out  1  one-cycle pulse on a misaligned request.
- inv  in  1  cache invalidate strobe.
- drv_addr  out  WORD_AW+1  halfword address to the flash driver.
- drv_read  out  1  read enable to the flash driver.
- drv_data  in  16  read data from the flash driver.
- drv_ack  in  1  driver idle/ready; low while a read is in progress.

Behaviour:
- Reset (async, rst_n=0): state IDLE; bus_ack=0, bus_err=0, bus_rdata=0, drv_read=0, drv_addr=0; cache valid=0, tag=0, data=0.
- Word index W = bus_addr[WORD_AW+1:2].
- Halfword 2W maps to bus_rdata[15:0]; halfword 2W+1 maps to bus_rdata[31:16].
- IDLE, bus_req=1, bus_addr[1:0]!=0: bus_err=1 for the next cycle only; no flash access; state stays IDLE.
- IDLE, bus_req=1, aligned, valid and tag==W (hit): bus_rdata=cache data and bus_ack=1 on the next cycle (latency 1).
- IDLE, bus_req=1, aligned, miss: latch W, go to LO_WAIT.
- LO_WAIT:
  - Wait for drv_ack=1.
  - In that cycle, set drv_addr={W,0} and drv_read=1, load counter=READ_WAIT-1, go to LO_RD.
- LO_RD:
  - drv_read and drv_addr held stable; counter decrements each cycle.
  - At counter==0: capture drv_data into the low half, drop drv_read, go to LO_REL.
- LO_REL: wait for drv_ack=1 (driver returned to idle), then go to HI_WAIT.
- HI_WAIT, HI_RD, HI_REL: same as the LO states with drv_addr={W,1}; capture into the high half.
- Leaving HI_REL: go to DONE.
- DONE:
  - bus_rdata = assembled word; bus_ack=1 for exactly one cycle.
  - Cache tag=W, data=word, valid=1, unless the fetch was poisoned (see inv below).
  - Return to IDLE.
- Miss latency with an idle driver: 2*(READ_WAIT+1) + driver release time + 1 cycles.
- drv_read is never reasserted before drv_ack has returned to 1 after the previous release. drv_read is never high in IDLE or DONE.
- bus_ack and bus_err are never high in the same cycle. A new request is examined no earlier than the cycle after an ack or err.
- inv=1 clears valid immediately.
  - If a fetch is in progress, it completes and returns data normally but is marked poisoned: the word is not written into the cache.
  - inv in the same cycle as a hit lookup in IDLE forces a miss.
- Requester drops bus_req mid-fetch: the fetch runs to completion and fills the cache (if not poisoned); bus_ack still pulses.
- Driver held busy (drv_ack=0) indefinitely: the block waits indefinitely; there is no timeout.
- Reset mid-fetch: everything returns to its reset values immediately; drv_read drops asynchronously.

Test Plan:
- Reset, then bus_req with bus_addr=0x000010, flash halfwords 8=0xBEEF and 9=0xDEAD → two drv_read pulses, each READ_WAIT=10 cycles long, at drv_addr=8 then 9; bus_ack pulses once with bus_rdata=0xDEADBEEF.
- Repeat the read of 0x000010 → bus_ack on the next cycle with 0xDEADBEEF and no drv_read activity.
- Read 0x000012 → bus_err pulses for one cycle; no drv_read; state remains IDLE; next aligned read works.
- Miss on 0x000020 with inv pulsed during HI_RD → data returned correctly; a re-read of 0x000020 issues a flash access again (not cached).
- drv_ack held low for 50 cycles before the LO and HI phases → drv_read not asserted until drv_ack=1; data still correct.
- Assert rst_n=0 during LO_RD → drv_read=0 and bus_ack=0 immediately; after release, a read of the same address performs a full fetch.

Source files
------------

// File: rtl/flash_read_bridge.sv
// Bus-side front end for the 16-bit NOR flash driver: turns each 32-bit word read into two
// halfword flash reads and keeps a single-entry word cache.
module flash_read_bridge #(
  parameter int unsigned WORD_AW   = 21,
  parameter int unsigned READ_WAIT = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bus_req,
  input  logic [WORD_AW+1:0] bus_addr,
  output logic [31:0]        bus_rdata,
  output logic               bus_ack,
  output logic               bus_err,
  input  logic               inv,
  output logic [WORD_AW:0]   drv_addr,
  output logic               drv_read,
  input  logic [15:0]        drv_data,
  input  logic               drv_ack
);

  typedef enum logic [2:0] {
    StIdle, StLoWait, StLoRd, StLoRel, StHiWait, StHiRd, StHiRel, StDone
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_AW-1:0]   word_q, word_d;
  logic [WORD_AW-1:0]   tag_q, tag_d;
  logic [31:0]          data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 poison_q, poison_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [15:0]          lo_q, lo_d;
  logic [15:0]          hi_q, hi_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [WORD_AW:0]     drv_addr_q, drv_addr_d;
  logic                 drv_read_q, drv_read_d;

  logic [WORD_AW-1:0]   word_idx;
  logic                 aligned;
  logic                 hit;
  logic                 take_req;

  assign word_idx = bus_addr[WORD_AW+1:2];
  assign aligned  = (bus_addr[1:0] == 2'b00);
  assign hit      = valid_q && (tag_q == word_idx) && !inv;
  // The cycle carrying an ack/err still sees the old request level, so it is ignored.
  assign take_req = bus_req && !ack_q && !err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      word_q     <= '0;
      tag_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      poison_q   <= 1'b0;
      cnt_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      drv_addr_q <= '0;
      drv_read_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      poison_q   <= poison_d;
      cnt_q      <= cnt_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      drv_addr_q <= drv_addr_d;
      drv_read_q <= drv_read_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (take_req && aligned && !hit) state_d = StLoWait;
      StLoWait: if (drv_ack) state_d = StLoRd;
      StLoRd:   if (cnt_q == 8'd0) state_d = StLoRel;
      StLoRel:  if (drv_ack) state_d = StHiWait;
      StHiWait: if (drv_ack) state_d = StHiRd;
      StHiRd:   if (cnt_q == 8'd0) state_d = StHiRel;
      StHiRel:  if (drv_ack) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    word_d     = word_q;
    tag_d      = tag_q;
    data_d     = data_q;
    valid_d    = valid_q;
    poison_d   = poison_q;
    cnt_d      = cnt_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    drv_addr_d = drv_addr_q;
    drv_read_d = drv_read_q;
    unique case (state_q)
      StIdle: begin
        if (take_req) begin
          if (!aligned) begin
            err_d = 1'b1;
          end else if (hit) begin
            ack_d   = 1'b1;
            rdata_d = data_q;
          end else begin
            word_d   = word_idx;
            poison_d = 1'b0;
          end
        end
      end
      StLoWait, StHiWait: begin
        if (drv_ack) begin
          drv_addr_d = {word_q, (state_q == StHiWait)};
          drv_read_d = 1'b1;
          cnt_d      = 8'(READ_WAIT - 1);
        end
      end
      StLoRd, StHiRd: begin
        if (cnt_q == 8'd0) begin
          if (state_q == StLoRd) lo_d = drv_data;
          else                   hi_d = drv_data;
          drv_read_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StHiRel: begin
        if (drv_ack) begin
          ack_d   = 1'b1;
          rdata_d = {hi_q, lo_q};
        end
      end
      StDone: begin
        if (!poison_q && !inv) begin
          valid_d = 1'b1;
          tag_d   = word_q;
          data_d  = rdata_q;
        end
      end
      default: ;
    endcase
    // Invalidate wins over any fill; an in-flight fetch must not repopulate the cache.
    if (inv) begin
      valid_d = 1'b0;
      if (state_q != StIdle) poison_d = 1'b1;
    end
  end

  assign bus_rdata = rdata_q;
  assign bus_ack   = ack_q;
  assign bus_err   = err_q;
  assign drv_addr  = drv_addr_q;
  assign drv_read  = drv_read_q;

endmodule
